if_id_buffer: RTL

- Decoupling buffer between the fetch stage and the decode stage.
- Captures each fetched {address, instruction} pair into a small in-order FIFO and presents the head entry to decode with a valid/ready handshake.
- Back-pressures fetch when full.
- Discards all buffered, wrong-path instructions in one cycle when a taken branch (PCSrc) is signalled.

---
 rtl/if_id_buffer_if.sv | 64 ++++++
 rtl/if_id_buffer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer_if.sv
// ---------------------------------------------------------------------------
// if_id_buffer_if
//
// Bundles the fetch-side and decode-side signals of the IF/ID decoupling
// buffer. Clock and reset are not part of the bundle.
//
// Signals:
//   if_valid     fetch -> buffer   fetch presents a valid {pc, instr} pair
//   if_pc        fetch -> buffer   address of the presented instruction
//   if_instr     fetch -> buffer   instruction word at if_pc
//   if_ready     buffer -> fetch   buffer accepts a pair this cycle
//   flush        branch -> buffer  taken branch, discard all contents
//   id_valid     buffer -> decode  head entry valid
//   id_ready     decode -> buffer  decode consumes head this cycle
//   id_pc        buffer -> decode  head entry address
//   id_pc_plus4  buffer -> decode  id_pc + 4
//   id_instr     buffer -> decode  head entry instruction
//   flush_count  buffer -> observer  (IFID_STATS_EN only) effective flushes
//   stall_cycles buffer -> observer  (IFID_STATS_EN only) fetch stall cycles
//
// Modports:
//   slave  : the buffer itself
//   master : the surrounding pipeline (fetch, branch unit, decode)
//
// Optional feature macro: IFID_STATS_EN
// ---------------------------------------------------------------------------
interface if_id_buffer_if;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
`ifdef IFID_STATS_EN
  logic [15:0] flush_count;
  logic [15:0] stall_cycles;

  modport slave (
    input  if_valid, if_pc, if_instr, flush, id_ready,
    output if_ready, id_valid, id_pc, id_pc_plus4, id_instr,
    output flush_count, stall_cycles
  );

  modport master (
    output if_valid, if_pc, if_instr, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_pc_plus4, id_instr,
    input  flush_count, stall_cycles
  );
`else
  modport slave (
    input  if_valid, if_pc, if_instr, flush, id_ready,
    output if_ready, id_valid, id_pc, id_pc_plus4, id_instr
  );

  modport master (
    output if_valid, if_pc, if_instr, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_pc_plus4, id_instr
  );
`endif
endinterface : if_id_buffer_if

// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------------------
// if_id_buffer
//
// Decoupling buffer between the fetch and decode stages. Each accepted
// {pc, instr} pair is written into a small in-order FIFO; the head entry is
// presented to decode with a valid/ready handshake. Fetch is back-pressured
// when the FIFO is full. A taken branch (flush) discards every buffered,
// wrong-path entry in a single cycle.
//
// There is no bypass path: a pair written at edge N is visible on the id_*
// outputs in the cycle after edge N. With id_ready held high the buffer
// sustains one instruction per cycle.
//
// Parameters:
//   DEPTH     number of entries; power of two, at least 2
//   NOP_WORD  instruction word shown to decode when nothing is valid
//
// Ports:
//   clk  rising-edge clock for all state
//   rst  synchronous, active-high reset
//   bus  if_id_buffer_if.slave (fetch, flush and decode signals)
//
// Optional feature macro: IFID_STATS_EN
//   When defined, bus.flush_count counts flushes that actually discarded
//   something (buffer non-empty or a push was pending) and bus.stall_cycles
//   counts cycles in which fetch was valid but refused. Both saturate at
//   16'hFFFF and clear on rst. When undefined, neither counter exists.
// ---------------------------------------------------------------------------
module if_id_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  if_id_buffer_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic   full;
  logic   empty;
  logic   if_ready_int;
  logic   id_valid_int;
  logic   push;
  logic   pop;
  entry_t head;

  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (here unconditionally), so no latch can be inferred.
  always_comb begin
    full         = (count == FULL_CNT);
    empty        = (count == '0);
    // Both handshakes are masked by rst so the pipeline sees an idle buffer
    // for the whole reset cycle, even before count has been cleared.
    if_ready_int = !rst && !full;
    id_valid_int = !rst && !empty;
    // A flush cancels any transfer in the same cycle: the pair offered by
    // fetch is on the wrong path and decode must not advance either.
    push         = bus.if_valid && if_ready_int && !bus.flush;
    pop          = id_valid_int && bus.id_ready && !bus.flush;
    head         = mem[rd_ptr];
  end

  // -------------------------------------------------------------------------
  // Entry storage
  // -------------------------------------------------------------------------
  // NOTE: the entry array has no reset. Validity is tracked entirely by
  // count, so clearing the data would add reset fan-out for nothing. An
  // entry changes only when a push targets its own slot; inputs are ignored
  // otherwise, so garbage on if_pc/if_instr with if_valid=0 is harmless.
  always_ff @(posedge clk) begin
    if (push) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of process order.
      mem[wr_ptr] <= '{pc: bus.if_pc, instr: bus.if_instr};
    end
  end

  // -------------------------------------------------------------------------
  // Pointers and occupancy
  // -------------------------------------------------------------------------
  // Priority: rst, then flush, then push/pop. Pointers wrap naturally at
  // DEPTH because DEPTH is a power of two and the pointers are PTR_W wide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // When nothing is valid decode sees a clean bubble (pc 0, NOP_WORD)
  // rather than stale storage contents.
  assign bus.if_ready    = if_ready_int;
  assign bus.id_valid    = id_valid_int;
  assign bus.id_pc       = id_valid_int ? head.pc          : 32'd0;
  assign bus.id_pc_plus4 = id_valid_int ? head.pc + 32'd4  : 32'd0;
  assign bus.id_instr    = id_valid_int ? head.instr       : NOP_WORD;

`ifdef IFID_STATS_EN
  // -------------------------------------------------------------------------
  // Statistics counters
  // -------------------------------------------------------------------------
  logic [15:0] flush_count_q;
  logic [15:0] stall_cycles_q;
  logic        flush_hit;
  logic        stall_hit;

  always_comb begin
    // A flush only counts when it threw something away: buffered entries,
    // or a pair fetch was offering that would otherwise have been taken.
    flush_hit = bus.flush && (!empty || (bus.if_valid && if_ready_int));
    stall_hit = bus.if_valid && !if_ready_int && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (flush_hit && (flush_count_q != 16'hFFFF)) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
      if (stall_hit && (stall_cycles_q != 16'hFFFF)) begin
        stall_cycles_q <= stall_cycles_q + 16'd1;
      end
    end
  end

  assign bus.flush_count  = flush_count_q;
  assign bus.stall_cycles = stall_cycles_q;
`endif

endmodule : if_id_buffer
